// File: rtl/weight_pkg.sv
// Shared constants and types for the layer weight memory (weight_bank).
package weight_pkg;

  localparam int unsigned W_WIDTH = 10;
  localparam int unsigned W_DEPTH = 128;
  localparam int unsigned W_ADDR  = $clog2(W_DEPTH);

  typedef logic signed [W_WIDTH-1:0] weight_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/weight_deserializer.sv
// Serial-to-parallel weight loader, MSB first. With WEIGHT_PARITY_EN each word
// carries a trailing even-parity bit and par_err flags a bad word.
module weight_deserializer
  import weight_pkg::*;
#(
  parameter int unsigned WIDTH = W_WIDTH
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             we,
  input  logic             din,
  output logic             word_valid,
  output logic [WIDTH-1:0] word
`ifdef WEIGHT_PARITY_EN
  ,
  output logic             par_err
`endif
);

`ifdef WEIGHT_PARITY_EN
  localparam int unsigned NB = WIDTH + 1;
`else
  localparam int unsigned NB = WIDTH;
`endif
  localparam int unsigned CW = $clog2(NB);
  localparam int unsigned SW = NB - 1;

  logic [CW-1:0] bit_cnt;
  logic [SW-1:0] shreg;
  logic          last;

  // The final bit is taken straight from din so the word writes on the same edge.
  assign last       = we && (bit_cnt == CW'(NB - 1));
  assign word_valid = last;

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (!we) begin
      bit_cnt <= '0;
    end else begin
      shreg   <= {shreg[SW-2:0], din};
      bit_cnt <= last ? '0 : bit_cnt + 1'b1;
    end
  end

`ifdef WEIGHT_PARITY_EN
  assign word    = shreg;
  assign par_err = ^{shreg, din};
`else
  assign word = {shreg, din};
`endif

endmodule

// File: rtl/weight_bank.sv
// Per-layer weight memory: serial load port plus vector read with valid/ready.
// Optional WEIGHT_PARITY_EN adds per-word even parity and a sticky ParErr.
module weight_bank
  import weight_pkg::*;
#(
  parameter  int unsigned WIDTH  = W_WIDTH,
  parameter  int unsigned DEPTH  = W_DEPTH,
  parameter  int unsigned VEC    = 10,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                        Clock,
  input  logic                        Rst,
  input  logic                        WE,
  input  logic                        In,
  output logic [ADDR_W:0]             LoadCount,
  input  logic                        ReqValid,
  input  logic [ADDR_W-1:0]           ReqAddr,
  output logic                        ReqReady,
  output logic                        RspValid,
  input  logic                        RspReady,
  output logic [VEC-1:0][WIDTH-1:0]   RspData,
  output logic                        ParErr
);

  localparam int unsigned     IW     = $clog2(VEC + 1);
  localparam logic [IW-1:0]   LAST_I = IW'(VEC);
  localparam logic [ADDR_W:0] FULL   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] TOP_A = ADDR_W'(DEPTH - 1);

  wb_state_t         state;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_addr;
  logic [IW-1:0]     idx;
  logic [WIDTH-1:0]  rd_q;
  logic [WIDTH-1:0]  word;
  logic              word_valid;
  logic              accept;

`ifdef WEIGHT_PARITY_EN
  logic par_err;

  weight_deserializer #(.WIDTH(WIDTH)) u_deser (
    .Clock      (Clock),
    .Rst        (Rst),
    .we         (WE),
    .din        (In),
    .word_valid (word_valid),
    .word       (word),
    .par_err    (par_err)
  );

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst)                        ParErr <= 1'b0;
    else if (word_valid && par_err) ParErr <= 1'b1;
  end
`else
  weight_deserializer #(.WIDTH(WIDTH)) u_deser (
    .Clock      (Clock),
    .Rst        (Rst),
    .we         (WE),
    .din        (In),
    .word_valid (word_valid),
    .word       (word)
  );

  assign ParErr = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      wr_ptr    <= '0;
      LoadCount <= '0;
    end else if (word_valid) begin
      wr_ptr <= (wr_ptr == TOP_A) ? '0 : wr_ptr + 1'b1;
      if (LoadCount != FULL) LoadCount <= LoadCount + 1'b1;
    end
  end

  assign rd_addr = base + ADDR_W'(idx);

  // Read and write share an edge, so a colliding fetch sees the old word.
  always_ff @(posedge Clock) begin
    if (word_valid) mem[wr_ptr] <= word;
    if (state == FETCH && idx != LAST_I) rd_q <= mem[rd_addr];
  end

  // A new request may be taken on the same edge the response is consumed,
  // giving one vector every VEC+2 cycles.
  assign ReqReady = !Rst && !WE &&
                    (state == IDLE || (state == RESP && RspReady));
  assign accept   = ReqValid && ReqReady;
  assign RspValid = (state == RESP);

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      base    <= '0;
      idx     <= '0;
      RspData <= '0;
    end else begin
      if (state == FETCH) begin
        for (int unsigned k = 0; k < VEC; k++) begin
          if (idx == IW'(k + 1)) RspData[k] <= rd_q;
        end
        if (idx == LAST_I) state <= RESP;
        else               idx   <= idx + 1'b1;
      end
      if (state == RESP && RspReady) state <= IDLE;
      if (accept) begin
        base  <= ReqAddr;
        idx   <= '0;
        state <= FETCH;
      end
    end
  end

endmodule

// File: tb/tb_weight_bank.sv
// Self-checking bench for weight_bank: directed scenarios plus a randomized
// phase, checked every cycle against a behavioural model of the memory.
module tb_weight_bank;
  import weight_pkg::*;

  localparam int WIDTH = 10;
  localparam int DEPTH = 128;
  localparam int VEC   = 10;
  localparam int AW    = 7;
`ifdef WEIGHT_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic                      Clock = 1'b0;
  logic                      Rst, WE, In, ReqValid, RspReady;
  logic                      ReqReady, RspValid, ParErr;
  logic [AW:0]               LoadCount;
  logic [AW-1:0]             ReqAddr;
  logic [VEC-1:0][WIDTH-1:0] RspData;

  weight_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .VEC(VEC)) dut (
    .Clock     (Clock),
    .Rst       (Rst),
    .WE        (WE),
    .In        (In),
    .LoadCount (LoadCount),
    .ReqValid  (ReqValid),
    .ReqAddr   (ReqAddr),
    .ReqReady  (ReqReady),
    .RspValid  (RspValid),
    .RspReady  (RspReady),
    .RspData   (RspData),
    .ParErr    (ParErr)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mem   [DEPTH];
  bit m_known [DEPTH];
  bit m_bits  [$];
  int m_load, m_wp, m_base, m_k;
  bit m_par, m_active;
  int m_data  [VEC];
  bit m_dknown[VEC];
  bit m_acc, m_hs;
  int m_a, m_v;
`ifdef WEIGHT_PARITY_EN
  bit m_p;
  bit par_flip = 1'b0;
`endif

  function automatic bit model_valid();
    return m_active && (m_k >= VEC + 1);
  endfunction

  function automatic bit model_ready();
    return !Rst && !WE && (!m_active || (model_valid() && RspReady));
  endfunction

  always @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      m_bits.delete();
      m_load = 0; m_wp = 0; m_par = 0; m_active = 0; m_k = 0;
    end else begin
      m_acc = ReqValid && model_ready();
      m_hs  = model_valid() && RspReady;
      if (m_active && m_k < VEC) begin
        m_a = (m_base + m_k) % DEPTH;
        m_data[m_k]   = m_mem[m_a];
        m_dknown[m_k] = m_known[m_a];
      end
      if (m_hs) m_active = 0;
      if (m_acc) begin
        m_active = 1; m_base = int'(ReqAddr); m_k = 0;
      end else if (m_active && m_k <= VEC) begin
        m_k++;
      end
      if (WE) begin
        m_bits.push_back(In);
        if (m_bits.size() == NB) begin
          m_v = 0;
          for (int b = 0; b < WIDTH; b++) m_v = m_v * 2 + int'(m_bits[b]);
`ifdef WEIGHT_PARITY_EN
          m_p = 0;
          for (int b = 0; b < NB; b++) m_p ^= m_bits[b];
          if (m_p) m_par = 1;
`endif
          m_mem[m_wp]   = m_v;
          m_known[m_wp] = 1;
          m_wp = (m_wp + 1) % DEPTH;
          if (m_load < DEPTH) m_load++;
          m_bits.delete();
        end
      end else begin
        m_bits.delete();
      end
    end
  end

  always @(negedge Clock) begin
    if (!Rst) begin
      chk("LoadCount", LoadCount, m_load);
      chk("ParErr", ParErr, m_par);
      chk("RspValid", RspValid, model_valid());
      chk("ReqReady", ReqReady, model_ready());
      if (model_valid()) begin
        for (int i = 0; i < VEC; i++)
          if (m_dknown[i]) chk("RspData", RspData[i], m_data[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_word(input int val);
    logic [WIDTH-1:0] d;
    d = val[WIDTH-1:0];
    for (int b = WIDTH - 1; b >= 0; b--) begin
      WE = 1'b1; In = d[b]; tick();
    end
`ifdef WEIGHT_PARITY_EN
    WE = 1'b1; In = (^d) ^ par_flip; tick();
`endif
  endtask

  task automatic idle(input int n);
    WE = 1'b0; In = 1'b0;
    repeat (n) tick();
  endtask

  task automatic accept_req(input int addr);
    bit got = 0;
    ReqValid = 1'b1; ReqAddr = addr[AW-1:0];
    for (int t = 0; t < 100 && !got; t++) begin
      got = ReqReady;
      tick();
    end
    ReqValid = 1'b0;
    chk("accept_timeout", got, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int t = 0; t < 100; t++) begin
      tick(); lat++;
      if (RspValid) break;
    end
    chk("valid_timeout", RspValid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scenarios ----------------
  initial begin
    int lat;
    logic [VEC-1:0][WIDTH-1:0] snap;
    int we_run;
    bit we_on;

    Rst = 1'b1; WE = 1'b0; In = 1'b0; ReqValid = 1'b0; ReqAddr = '0; RspReady = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_LoadCount", LoadCount, 0);
    chk("rst_ReqReady", ReqReady, 0);
    chk("rst_RspValid", RspValid, 0);
    chk("rst_ParErr", ParErr, 0);
    for (int i = 0; i < VEC; i++) chk("rst_RspData", RspData[i], 0);
    Rst = 1'b0;
    tick();
    chk("post_rst_ReqReady", ReqReady, 1);

    // Signed load -5..4, vector from address 0
    for (int k = 0; k < 10; k++) send_word(k - 5);
    idle(1);
    chk("t2_LoadCount", LoadCount, 10);
    RspReady = 1'b1;
    accept_req(0);
    wait_valid(lat);
    chk("t2_latency", lat, 11);
    for (int i = 0; i < VEC; i++) chk("t2_data", weight_t'(RspData[i]), i - 5);
    tick();
    chk("t2_drop", RspValid, 0);

    // Partial word discarded, then 10'h155
    for (int b = 0; b < 4; b++) begin
      WE = 1'b1; In = 1'($urandom); tick();
    end
    idle(1);
    send_word('h155);
    idle(1);
    chk("t5_LoadCount", LoadCount, 11);
    accept_req(10);
    wait_valid(lat);
    chk("t5_word", RspData[0], 'h155);
    tick();

`ifdef WEIGHT_PARITY_EN
    par_flip = 1'b1;
    send_word('h003);
    par_flip = 1'b0;
    idle(1);
    chk("t6_ParErr_set", ParErr, 1);
    send_word('h007);
    idle(1);
    chk("t6_ParErr_sticky", ParErr, 1);
`else
    chk("t6_ParErr_off", ParErr, 0);
`endif

    // Reset in the middle of a fetch
    accept_req(0);
    tick(); tick();
    #2 Rst = 1'b1;
    #1;
    chk("t1_RspValid", RspValid, 0);
    chk("t1_ReqReady", ReqReady, 0);
    chk("t1_LoadCount", LoadCount, 0);
    chk("t1_ParErr", ParErr, 0);
    for (int i = 0; i < VEC; i++) chk("t1_RspData", RspData[i], 0);
    tick();
    Rst = 1'b0;
    #1;
    chk("t1_ReqReady_release", ReqReady, 1);
    tick();

    // Full fill with word k = k, then a wrapping read
    for (int k = 0; k < DEPTH; k++) send_word(k);
    idle(1);
    chk("t3_LoadCount", LoadCount, 128);
    accept_req(125);
    wait_valid(lat);
    chk("t3_latency", lat, 11);
    for (int i = 0; i < VEC; i++) chk("t3_data", RspData[i], (125 + i) % 128);
    tick();
    send_word(-1);
    idle(1);
    chk("t3_saturate", LoadCount, 128);

    // Back-pressure: response held for 20 cycles
    RspReady = 1'b0;
    accept_req(3);
    wait_valid(lat);
    snap = RspData;
    for (int t = 0; t < 20; t++) begin
      ReqValid = 1'b1; ReqAddr = AW'($urandom);
      tick();
      chk("t4_valid_hold", RspValid, 1);
      chk("t4_ReqReady", ReqReady, 0);
      for (int i = 0; i < VEC; i++) chk("t4_data_hold", RspData[i], snap[i]);
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    tick();
    chk("t4_valid_drop", RspValid, 0);

    // Randomized traffic, including writes colliding with fetches
    we_run = 0; we_on = 0;
    for (int c = 0; c < 3000; c++) begin
      if (we_run == 0) begin
        we_on  = ($urandom_range(0, 2) != 0);
        we_run = we_on ? $urandom_range(1, 35) : $urandom_range(1, 6);
      end
      we_run--;
      WE       = we_on;
      In       = 1'($urandom);
      ReqValid = ($urandom_range(0, 2) == 0);
      ReqAddr  = ($urandom_range(0, 1) == 0) ? AW'((m_wp + $urandom_range(0, 3)) % DEPTH)
                                             : AW'($urandom);
      RspReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    WE = 1'b0; ReqValid = 1'b0; RspReady = 1'b1;
    repeat (2 * VEC + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
